hazard_ctrl: RTL

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 131 +++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch redirects and data-memory wait freezes.
// Optional perf counters (stall_cnt, flush_cnt) are enabled by defining HAZARD_PERF_CNT_EN.
module hazard_ctrl #(
  parameter int unsigned WAIT_MAX = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_uses_rs2,
  input  logic [4:0] ex_rd,
  input  logic       ex_memread,
  input  logic       ex_branch_taken,
  input  logic       dmem_req,
  input  logic       dmem_ready,
  output logic       pc_stall,
  output logic       ifid_stall,
  output logic       ifid_flush,
  output logic       idex_stall,
  output logic       idex_bubble,
  output logic       exmem_stall,
  output logic [1:0] state_o,
  output logic       mem_timeout,
  output logic       timeout_err
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
`endif
);

  typedef enum logic [1:0] {
    StRun      = 2'd0,
    StLuStall  = 2'd1,
    StMemWait  = 2'd2,
    StRedirect = 2'd3
  } state_e;

  localparam logic [15:0] WaitMax  = 16'(WAIT_MAX);
  localparam logic [15:0] WaitLast = 16'(WAIT_MAX - 1);

  state_e      state_q, state_d;
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic        timeout_err_q;
  logic        lu, lu_ok, mw;

  assign lu = ex_memread && (ex_rd != 5'd0) &&
              ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));
  assign mw = dmem_req && !dmem_ready;
  // The cycle right after a load-use stall or redirect must not re-stall on the same hazard.
  assign lu_ok = lu && ((state_q == StRun) || (state_q == StMemWait));

  always_comb begin
    pc_stall    = 1'b0;
    ifid_stall  = 1'b0;
    ifid_flush  = 1'b0;
    idex_stall  = 1'b0;
    idex_bubble = 1'b0;
    exmem_stall = 1'b0;
    state_d     = StRun;
    if (mw) begin
      pc_stall    = 1'b1;
      ifid_stall  = 1'b1;
      idex_stall  = 1'b1;
      exmem_stall = 1'b1;
      state_d     = StMemWait;
    end else if (ex_branch_taken) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      state_d     = StRedirect;
    end else if (lu_ok) begin
      pc_stall    = 1'b1;
      ifid_stall  = 1'b1;
      idex_bubble = 1'b1;
      state_d     = StLuStall;
    end
    if (!rst) begin
      pc_stall    = 1'b0;
      ifid_stall  = 1'b0;
      ifid_flush  = 1'b0;
      idex_stall  = 1'b0;
      idex_bubble = 1'b0;
      exmem_stall = 1'b0;
    end
  end

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if ((state_d == StMemWait) && (state_q != StMemWait)) begin
      wait_cnt_d = 16'd0;
    end else if ((state_q == StMemWait) && mw && (wait_cnt_q != WaitMax)) begin
      // Saturating at WAIT_MAX keeps the timeout to a single pulse per wait.
      wait_cnt_d = wait_cnt_q + 16'd1;
    end
  end

  assign mem_timeout = rst && (state_q == StMemWait) && mw && (wait_cnt_q == WaitLast);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= StRun;
      wait_cnt_q    <= 16'd0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      timeout_err_q <= timeout_err_q || mem_timeout;
    end
  end

  assign state_o     = state_q;
  assign timeout_err = timeout_err_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_q + {31'd0, pc_stall};
      flush_cnt_q <= flush_cnt_q + {31'd0, ifid_flush};
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule
